// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy scoreboard (optional REGFILE_BYPASS_EN forwarding)
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int N_RD   = 2,
  parameter int N_WR   = 2
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [N_RD-1:0]                  rd_en,
  input  logic [N_RD*$clog2(DEPTH)-1:0]    rd_addr,
  output logic [N_RD*DATA_W-1:0]           rd_data,
  output logic [N_RD-1:0]                  rd_busy,
  input  logic [N_WR-1:0]                  wr_en,
  input  logic [N_WR*$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [N_WR*DATA_W-1:0]           wr_data,
  input  logic                             rsv_en,
  input  logic [$clog2(DEPTH)-1:0]         rsv_addr,
  output logic [$clog2(DEPTH):0]           busy_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  rsv_hit;
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic              set_new;
  logic [AW:0]       clr_cnt;
  logic [AW:0]       cnt_nxt;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins. Register 0 is never hit.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
    end
    for (int r = 1; r < DEPTH; r++) begin
      for (int w = 0; w < N_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[w*DATA_W +: DATA_W];
        end
      end
      rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
    end
  end

  // Busy counter delta: one newly-set bit at most, minus every busy bit cleared by a write that is not re-reserved.
  always_comb begin
    set_new = |(rsv_hit & ~busy);
    clr_cnt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (busy[r] && wr_hit[r] && !rsv_hit[r]) begin
        clr_cnt = clr_cnt + CNT_ONE;
      end
    end
    cnt_nxt = busy_cnt + {{AW{1'b0}}, set_new} - clr_cnt;
  end

  // Register storage; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          mem[r] <= wr_val[r];
        end
      end
    end
  end

  // Scoreboard bits and population counter; a reservation overrides a same-cycle clear (new producer wins).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~wr_hit) | rsv_hit;
      busy_cnt <= cnt_nxt;
    end
  end

  // Combinational read ports; forwarding is gated by reset so outputs stay 0 while nrst is low.
  always_comb begin
    logic [AW-1:0] a;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    for (int p = 0; p < N_RD; p++) begin
      a = rd_addr[p*AW +: AW];
      if (rd_en[p]) begin
        rd_data[p*DATA_W +: DATA_W] = mem[a];
        rd_busy[p]                  = (a != '0) && busy[a];
`ifdef REGFILE_BYPASS_EN
        if (nrst && wr_hit[a]) begin
          rd_data[p*DATA_W +: DATA_W] = wr_val[a];
          rd_busy[p]                  = rsv_hit[a];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic            clk;
  logic            nrst;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic [NW-1:0]   wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [AW:0]     busy_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];

  reg_file_mp #(.DATA_W(DW), .DEPTH(DEPTH), .N_RD(NR), .N_WR(NW)) dut (
    .clk(clk), .nrst(nrst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register 0 is untouchable; writes in port order so the last port wins; reservation applied after writes.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        int a;
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != 0) begin
          m_mem[a] = wr_data[w*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[int'(rsv_addr)] = 1'b1;
    end
  end

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < DEPTH; r++) if (m_busy[r]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int p);
    int a;
    logic [DW-1:0] v;
    a = int'(rd_addr[p*AW +: AW]);
    if (!nrst || !rd_en[p]) return '0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (a != 0 && wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int p);
    int a;
    logic b;
    a = int'(rd_addr[p*AW +: AW]);
    if (!nrst || !rd_en[p] || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) b = rsv_en && (int'(rsv_addr) == a);
`endif
    return b;
  endfunction

  // Compare every output against the model once per cycle, on the falling edge.
  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("cmp_rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(exp_data(p)));
      chk($sformatf("cmp_rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_busy(p)));
    end
    chk("cmp_busy_cnt", 64'(busy_cnt), nrst ? 64'(m_cnt()) : 64'd0);
  end

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a[AW-1:0];
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic rsv(input int a);
    rsv_en = 1'b1;
    rsv_addr = a[AW-1:0];
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    // Reset: every address reads 0 on both ports, even with a write presented at an edge.
    for (int a = 0; a < DEPTH; a++) begin
      step();
      idle();
      rd(0, a); rd(1, DEPTH - 1 - a);
      wr(0, 5, 32'hCAFE0000 + a); rsv(6);
      #1;
      chk("rst_rd0", 64'(rd_data[31:0]), 64'd0);
      chk("rst_rd1", 64'(rd_data[63:32]), 64'd0);
      chk("rst_busy", 64'(rd_busy), 64'd0);
      chk("rst_cnt", 64'(busy_cnt), 64'd0);
    end
    step();
    idle();
    nrst = 1'b1;
    step();
    rd(0, 5); rd(1, 6); #1;
    chk("post_rst_r5", 64'(rd_data[31:0]), 64'd0);
    chk("post_rst_busy_r6", 64'(rd_busy[1]), 64'd0);
    chk("post_rst_cnt", 64'(busy_cnt), 64'd0);

    // Same-address dual write: highest port wins.
    idle(); wr(0, 5, 32'hDEADBEEF); wr(1, 5, 32'h12345678);
    step(); idle();
    rd(0, 5); #1;
    chk("dual_wr_r5", 64'(rd_data[31:0]), 64'h12345678);
    rd_en[1] = 1'b0; rd_addr[AW +: AW] = 5'd5; #1;
    chk("rd_dis_data", 64'(rd_data[63:32]), 64'd0);

    // Register 0: write and reservation ignored.
    step(); idle(); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'h11111111); rsv(0);
    step(); idle(); rd(0, 0); rd(1, 0); #1;
    chk("r0_data", 64'(rd_data[31:0]), 64'd0);
    chk("r0_busy", 64'(rd_busy[0]), 64'd0);
    chk("r0_cnt", 64'(busy_cnt), 64'd0);

    // Reservations and clear-by-write.
    step(); idle(); rsv(3);
    step(); idle(); #1;
    chk("rsv_r3_cnt", 64'(busy_cnt), 64'd1);
    rsv(7);
    step(); idle(); rd(1, 3); rd(0, 7); #1;
    chk("rsv_r7_cnt", 64'(busy_cnt), 64'd2);
    chk("busy_r3", 64'(rd_busy[1]), 64'd1);
    step(); idle(); wr(1, 3, 32'h33);
    step(); idle(); rd(0, 3); rd(1, 7); #1;
    chk("wr_r3_cnt", 64'(busy_cnt), 64'd1);
    chk("wr_r3_busy", 64'(rd_busy[0]), 64'd0);
    chk("wr_r3_data", 64'(rd_data[31:0]), 64'h33);
    chk("r7_still_busy", 64'(rd_busy[1]), 64'd1);
    // Re-reserving a busy register leaves the count alone; writing an idle register does too.
    step(); idle(); rsv(7); wr(0, 4, 32'h44);
    step(); idle(); #1;
    chk("rersv_cnt", 64'(busy_cnt), 64'd1);

    // Reserve and write the same register in one cycle.
    rsv(9); wr(0, 9, 32'hA5);
    step(); idle(); rd(0, 9); #1;
    chk("rsvwr_r9_data", 64'(rd_data[31:0]), 64'hA5);
    chk("rsvwr_r9_busy", 64'(rd_busy[0]), 64'd1);
    chk("rsvwr_cnt", 64'(busy_cnt), 64'd2);
    wr(1, 9, 32'h5A); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_r9_data", 64'(rd_data[31:0]), 64'h5A);
    chk("byp_r9_busy", 64'(rd_busy[0]), 64'd0);
`else
    chk("nobyp_r9_data", 64'(rd_data[31:0]), 64'hA5);
    chk("nobyp_r9_busy", 64'(rd_busy[0]), 64'd1);
`endif
    step(); idle(); rd(0, 9); #1;
    chk("r9_new_data", 64'(rd_data[31:0]), 64'h5A);
    chk("r9_clr_cnt", 64'(busy_cnt), 64'd1);

    // Two busy bits cleared in the same edge.
    rsv(10); step(); idle(); rsv(11); step(); idle(); #1;
    chk("cnt_three", 64'(busy_cnt), 64'd3);
    wr(0, 10, 32'h10); wr(1, 11, 32'h11);
    step(); idle(); #1;
    chk("dual_clr_cnt", 64'(busy_cnt), 64'd1);

    // Mid-cycle asynchronous reset with four busy registers and a pending write.
    rsv(12); step(); idle(); rsv(13); step(); idle(); rsv(14); step(); idle(); #1;
    chk("cnt_four", 64'(busy_cnt), 64'd4);
    wr(0, 20, 32'h77); rd(1, 20); rd(0, 12);
    #1 nrst = 1'b0;
    #1;
    chk("arst_rd20", 64'(rd_data[63:32]), 64'd0);
    chk("arst_busy12", 64'(rd_busy[0]), 64'd0);
    chk("arst_cnt", 64'(busy_cnt), 64'd0);
    step();
    idle(); nrst = 1'b1;
    step(); rd(0, 20); rd(1, 7); #1;
    chk("arst_no_commit", 64'(rd_data[31:0]), 64'd0);
    chk("arst_r7_busy", 64'(rd_busy[1]), 64'd0);

    // Pseudo-random traffic on a small address window to provoke collisions; checked by the compare process.
    for (int i = 0; i < 200; i++) begin
      step(); idle();
      for (int p = 0; p < NR; p++) if ($urandom_range(0, 3) != 0) rd(p, $urandom_range(0, 7));
      for (int w = 0; w < NW; w++) if ($urandom_range(0, 1) != 0) wr(w, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) rsv($urandom_range(0, 7));
    end
    step(); idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter DEPTH, default 32, number of registers (power of two, >= 2); AW = log2(DEPTH).
REQ-003 Parameter N_RD, default 2, number of read ports.
REQ-004 Parameter N_WR, default 2, number of write ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 rd_en  input  N_RD  per-port read enable.
REQ-008 rd_addr  input  N_RD*AW  per-port read address, port p in bits [p*AW +: AW].
REQ-009 rd_data  output  N_RD*DATA_W  per-port read data.
REQ-010 rd_busy  output  N_RD  per-port scoreboard busy flag for the addressed register.
REQ-011 wr_en  input  N_WR  per-port write enable.
REQ-012 wr_addr  input  N_WR*AW  per-port write address.
REQ-013 wr_data  input  N_WR*DATA_W  per-port write data.
REQ-014 rsv_en  input  1  reserve request: mark a register as awaiting a pending write.
REQ-015 rsv_addr  input  AW  register to reserve.
REQ-016 busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-017 Register 0 SHALL always read 0; writes and reservations to address 0 SHALL be ignored.
REQ-018 Writes SHALL take effect at the rising clk edge when wr_en[w]=1.
REQ-019 If two or more write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-020 Reads SHALL be combinational: rd_data[p] = stored register value when rd_en[p]=1, else 0.
REQ-021 rd_busy[p] SHALL be 0 when rd_en[p]=0 or rd_addr[p]=0, else the registered busy bit of rd_addr[p].
REQ-022 The busy bit of register r SHALL be set at the edge when rsv_en=1 and rsv_addr=r (r != 0).
REQ-023 The busy bit of register r SHALL clear at the edge when any enabled write port targets r.
REQ-024 Same-cycle reserve and write to the same r: the busy bit SHALL end set (new producer wins) and the data SHALL be written.
REQ-025 Reserving an already-busy register SHALL leave it busy with busy_cnt unchanged.
REQ-026 busy_cnt SHALL be a registered counter updated each edge by (+1 if a new bit is set) and (-k for the k distinct bits cleared), consistent with REQ-024/025; it SHALL never exceed DEPTH-1 nor underflow.
REQ-027 Writes to a non-busy register SHALL be accepted normally and SHALL NOT change busy_cnt.

Reset
REQ-028 On nrst=0 all registers SHALL clear to 0, all busy bits to 0 and busy_cnt to 0 immediately, without waiting for clk.
REQ-029 Writes and reservations presented while nrst=0 SHALL be discarded; first update occurs at the first rising edge after nrst deasserts.
REQ-030 During reset rd_data SHALL read 0 and rd_busy SHALL read 0.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 Defined: when an enabled write port targets rd_addr[p] != 0 in the same cycle and rd_en[p]=1, rd_data[p] SHALL return that write data (highest-index port per REQ-019) and rd_busy[p] SHALL read 0 unless rsv_en targets the same address.
REQ-033 Not defined: rd_data and rd_busy SHALL reflect stored state only; written values are visible from the next cycle.

Verification
REQ-034 Reset then read all addresses on every port -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-035 Write 0xDEADBEEF to r5 via port 0 and 0x12345678 to r5 via port 1 same cycle; read r5 next cycle -> 0x12345678.
REQ-036 Write 0xFFFFFFFF to r0; read r0 -> 0, busy_cnt=0 after rsv_addr=0.
REQ-037 Reserve r3, r7 on consecutive cycles -> busy_cnt 1 then 2, rd_busy=1 on r3; write r3 -> busy_cnt=1, rd_busy(r3)=0.
REQ-038 Same cycle: rsv r9 and write 0xA5 to r9 -> r9=0xA5, busy set, busy_cnt +1; with REGFILE_BYPASS_EN, read r9 during a write of 0x5A -> rd_data=0x5A, without -> old value 0xA5.
REQ-039 Assert nrst mid-cycle with busy_cnt=4 and pending write -> outputs 0 immediately, write not committed after release.
